// File: rtl/pixel_averager.sv
// ============================================================================
//  Module   : pixel_averager
//  Brief    : Downsamples a square frame by FACTORxFACTOR block averaging.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pixel_averager #(
  parameter int PIX_W       = 8,
  parameter int LOG2_FACTOR = 1,
  parameter int DST_DIM     = 28,
  parameter int SRC_AW      = 12,
  parameter int DST_AW      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [SRC_AW-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              wr_en,
  output logic [DST_AW-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

  localparam int c_FACTOR  = 1 << LOG2_FACTOR;
  localparam int c_SRC_DIM = DST_DIM * c_FACTOR;
  localparam int c_ACC_W   = PIX_W + 2 * LOG2_FACTOR;
  localparam int c_T_W     = 2 * LOG2_FACTOR;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_T_W-1:0]    r_tile;   // {ty, tx}, tx in the low bits so it runs fastest
  logic [DST_AW-1:0]   r_ox;
  logic [DST_AW-1:0]   r_oy;
  logic [c_ACC_W-1:0]  r_acc;

  logic                w_tile_last;
  logic                w_ox_last;
  logic                w_pix_last;
  logic [SRC_AW-1:0]   w_src_x;
  logic [SRC_AW-1:0]   w_src_y;

  assign w_tile_last = &r_tile;
  assign w_ox_last   = (r_ox == DST_AW'(DST_DIM - 1));
  assign w_pix_last  = w_ox_last && (r_oy == DST_AW'(DST_DIM - 1));

  // FACTOR is a power of two, so oy*FACTOR+ty is a plain concatenation.
  assign w_src_x = SRC_AW'({r_ox, r_tile[LOG2_FACTOR-1:0]});
  assign w_src_y = SRC_AW'({r_oy, r_tile[c_T_W-1:LOG2_FACTOR]});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tile  <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_tile <= '0;
            r_ox   <= '0;
            r_oy   <= '0;
            r_acc  <= '0;
          end
        end
        S_READ: begin
          r_tile <= r_tile + c_T_W'(1);
          // rd_data lags rd_addr by one cycle; nothing to add on the first read.
          if (r_tile != '0) r_acc <= r_acc + c_ACC_W'(rd_data);
        end
        S_DRAIN: begin
          r_acc <= r_acc + c_ACC_W'(rd_data);
        end
        S_WRITE: begin
          r_acc <= '0;
          if (w_ox_last) begin
            r_ox <= '0;
            r_oy <= r_oy + DST_AW'(1);
          end else begin
            r_ox <= r_ox + DST_AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    rd_addr     = '0;
    wr_addr     = '0;
    wr_data     = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) w_state_nxt = S_READ;
      end
      S_READ: begin
        rd_en   = 1'b1;
        rd_addr = w_src_y * SRC_AW'(c_SRC_DIM) + w_src_x;
        if (w_tile_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        wr_en       = 1'b1;
        wr_addr     = r_oy * DST_AW'(DST_DIM) + r_ox;
        wr_data     = r_acc[c_ACC_W-1 -: PIX_W];
        w_state_nxt = w_pix_last ? S_DONE : S_READ;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
